// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - keypad code entry sequencer with submit handshake, timeout and lockout
module keypad_entry_ctrl #(
    parameter int clk_freq     = 50_000_000,
    parameter int timeout_ms   = 5000,
    parameter int lockout_ms   = 30000,
    parameter int max_attempts = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_value,
    input  logic        keypress,
    input  logic        code_ack,
    input  logic        code_ok,
    output logic [15:0] code,
    output logic        code_valid,
    output logic [3:0]  ssd_0,
    output logic [3:0]  ssd_1,
    output logic [3:0]  ssd_2,
    output logic [3:0]  ssd_3,
    output logic [2:0]  digit_count,
    output logic        lockout,
    output logic        busy
);

    // Cycle counts are computed in 64 bits; real clock rates overflow 32-bit products.
    localparam longint TIMEOUT_CYC = longint'(timeout_ms) * longint'(clk_freq) / 1000;
    localparam longint LOCKOUT_CYC = longint'(lockout_ms) * longint'(clk_freq) / 1000;
    localparam longint MAX_CYC     = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
    localparam int     TW          = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_END = TW'(LOCKOUT_CYC - 1);
    localparam logic [2:0]    FAIL_LIMIT  = 3'(max_attempts);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        SUBMIT,
        LOCKOUT
    } state_t;

    state_t        state;
    logic          kp_q;
    logic [TW-1:0] timer;
    logic [2:0]    fail_cnt;

    logic key_evt;
    logic is_digit;

    assign key_evt  = keypress & ~kp_q;
    assign is_digit = (key_value <= 4'd9);

    assign ssd_0 = code[3:0];
    assign ssd_1 = code[7:4];
    assign ssd_2 = code[11:8];
    assign ssd_3 = code[15:12];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            kp_q        <= 1'b0;
            timer       <= '0;
            fail_cnt    <= 3'd0;
            code        <= 16'h0;
            code_valid  <= 1'b0;
            digit_count <= 3'd0;
            lockout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            kp_q <= keypress;
            case (state)
                IDLE: begin
                    if (key_evt && is_digit) begin
                        code        <= {12'h0, key_value};
                        digit_count <= 3'd1;
                        timer       <= '0;
                        state       <= ENTRY;
                    end
                end
                ENTRY: begin
                    // Every key event restarts the inactivity timer, even ignored keys.
                    if (key_evt) begin
                        timer <= '0;
                        if (is_digit) begin
                            if (digit_count != 3'd4) begin
                                code        <= {code[11:0], key_value};
                                digit_count <= digit_count + 3'd1;
                            end
                        end else begin
                            case (key_value)
                                4'hE: begin
                                    code        <= {4'h0, code[15:4]};
                                    digit_count <= digit_count - 3'd1;
                                    if (digit_count == 3'd1) state <= IDLE;
                                end
                                4'hF: begin
                                    code        <= 16'h0;
                                    digit_count <= 3'd0;
                                    state       <= IDLE;
                                end
                                4'hA: begin
                                    if (digit_count == 3'd4) begin
                                        code_valid <= 1'b1;
                                        busy       <= 1'b1;
                                        state      <= SUBMIT;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (timer == TIMEOUT_END) begin
                        code        <= 16'h0;
                        digit_count <= 3'd0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SUBMIT: begin
                    if (code_ack) begin
                        code_valid  <= 1'b0;
                        code        <= 16'h0;
                        digit_count <= 3'd0;
                        if (code_ok) begin
                            fail_cnt <= 3'd0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else if (fail_cnt + 3'd1 == FAIL_LIMIT) begin
                            fail_cnt <= 3'd0;
                            lockout  <= 1'b1;
                            timer    <= '0;
                            state    <= LOCKOUT;
                        end else begin
                            fail_cnt <= fail_cnt + 3'd1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCKOUT_END) begin
                        lockout <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - directed and randomized checks of keypad_entry_ctrl against a queue-based model
module tb_keypad_entry_ctrl;

    localparam int T_CYC = 20;
    localparam int L_CYC = 50;
    localparam int MAXA  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_value = 4'h0;
    logic        keypress = 1'b0;
    logic        code_ack = 1'b0;
    logic        code_ok = 1'b0;
    logic [15:0] code;
    logic        code_valid;
    logic [3:0]  ssd_0, ssd_1, ssd_2, ssd_3;
    logic [2:0]  digit_count;
    logic        lockout;
    logic        busy;

    int tests = 0;
    int fails = 0;

    keypad_entry_ctrl #(
        .clk_freq(1000), .timeout_ms(20), .lockout_ms(50), .max_attempts(3)
    ) dut (
        .clk(clk), .rst(rst), .key_value(key_value), .keypress(keypress),
        .code_ack(code_ack), .code_ok(code_ok), .code(code), .code_valid(code_valid),
        .ssd_0(ssd_0), .ssd_1(ssd_1), .ssd_2(ssd_2), .ssd_3(ssd_3),
        .digit_count(digit_count), .lockout(lockout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits as a queue (oldest first), plus a mode
    // and a few plain counters that follow the key/ack rules directly.
    int digits[$];
    int mode = 0;            // 0 idle, 1 entry, 2 submit, 3 lockout
    bit prev_kp = 1'b0;
    int quiet = 0;
    int fails_seen = 0;
    int lock_left = 0;

    function automatic int model_code();
        int c = 0;
        foreach (digits[i]) c = (c << 4) | digits[i];
        return c;
    endfunction

    task automatic model_step();
        bit ev;
        int k;
        if (rst) begin
            digits.delete(); mode = 0; prev_kp = 0; quiet = 0; fails_seen = 0; lock_left = 0;
            return;
        end
        ev = keypress && !prev_kp;
        prev_kp = keypress;
        k = int'(key_value);
        case (mode)
            0: if (ev && k <= 9) begin digits = '{k}; mode = 1; quiet = 0; end
            1: begin
                if (ev) begin
                    quiet = 0;
                    if (k <= 9) begin
                        if (digits.size() < 4) digits.push_back(k);
                    end else if (k == 14) begin
                        void'(digits.pop_back());
                        if (digits.size() == 0) mode = 0;
                    end else if (k == 15) begin
                        digits.delete(); mode = 0;
                    end else if (k == 10 && digits.size() == 4) begin
                        mode = 2;
                    end
                end else begin
                    quiet++;
                    if (quiet == T_CYC) begin digits.delete(); mode = 0; end
                end
            end
            2: if (code_ack) begin
                digits.delete();
                if (code_ok) begin
                    fails_seen = 0; mode = 0;
                end else begin
                    fails_seen++;
                    if (fails_seen == MAXA) begin
                        fails_seen = 0; mode = 3; lock_left = L_CYC;
                    end else mode = 0;
                end
            end
            default: begin
                lock_left--;
                if (lock_left == 0) mode = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_value = k; keypress = 1'b1; tick();
        keypress = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        tests++;
        if ({code, code_valid, digit_count, lockout, busy} !== 22'h0) begin
            fails++; $display("FAIL reset_outputs: got code=%h valid=%b count=%0d lockout=%b busy=%b, want all 0",
                              code, code_valid, digit_count, lockout, busy);
        end
        tests++;
        if ({ssd_3, ssd_2, ssd_1, ssd_0} !== 16'h0) begin
            fails++; $display("FAIL reset_ssd: got %h want 0000", {ssd_3, ssd_2, ssd_1, ssd_0});
        end
        rst = 1'b0; tick();
    endtask

    task automatic test_submit_ok();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
        tests++;
        if (code !== 16'h1234 || code_valid !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL submit_code: got code=%h valid=%b busy=%b want 1234/1/1", code, code_valid, busy);
        end
        tick(); tick(); tick();
        tests++;
        if (code !== 16'h1234 || code_valid !== 1'b1) begin
            fails++; $display("FAIL submit_hold: got code=%h valid=%b want 1234/1", code, code_valid);
        end
        code_ack = 1'b1; code_ok = 1'b1; tick();
        code_ack = 1'b0; code_ok = 1'b0;
        tests++;
        if (code !== 16'h0 || code_valid !== 1'b0 || busy !== 1'b0 || digit_count !== 3'd0) begin
            fails++; $display("FAIL submit_ack: got code=%h valid=%b busy=%b count=%0d want 0/0/0/0",
                              code, code_valid, busy, digit_count);
        end
    endtask

    task automatic test_backspace_clear();
        press(4'h5); press(4'h6); press(4'hE); press(4'h7);
        tests++;
        if (code !== 16'h0057 || digit_count !== 3'd2) begin
            fails++; $display("FAIL backspace: got code=%h count=%0d want 0057/2", code, digit_count);
        end
        tests++;
        if ({ssd_3, ssd_2, ssd_1, ssd_0} !== 16'h0057) begin
            fails++; $display("FAIL ssd_map: got %h want 0057", {ssd_3, ssd_2, ssd_1, ssd_0});
        end
        press(4'hF);
        tests++;
        if (code !== 16'h0 || digit_count !== 3'd0) begin
            fails++; $display("FAIL clear: got code=%h count=%0d want 0/0", code, digit_count);
        end
    endtask

    task automatic test_held_key();
        key_value = 4'h9; keypress = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        keypress = 1'b0; tick();
        tests++;
        if (code !== 16'h0009 || digit_count !== 3'd1) begin
            fails++; $display("FAIL held_key: got code=%h count=%0d want 0009/1", code, digit_count);
        end
        press(4'hF);
    endtask

    task automatic test_lockout();
        int n;
        for (int a = 0; a < 3; a++) begin
            press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(4'hA);
            code_ack = 1'b1; code_ok = 1'b0; tick();
            code_ack = 1'b0;
            if (a < 2) begin
                tests++;
                if (lockout !== 1'b0 || busy !== 1'b0) begin
                    fails++; $display("FAIL early_lockout: attempt %0d got lockout=%b busy=%b want 0/0", a, lockout, busy);
                end
            end
        end
        n = 0;
        while (lockout === 1'b1 && n < 200) begin
            n++;
            key_value = 4'h5; keypress = n[0];
            tick();
            if (code !== 16'h0 || digit_count !== 3'd0) begin
                tests++; fails++;
                $display("FAIL lockout_keys: got code=%h count=%0d want 0/0", code, digit_count);
            end
        end
        keypress = 1'b0; tick();
        tests++;
        if (n !== L_CYC) begin
            fails++; $display("FAIL lockout_len: got %0d cycles want %0d", n, L_CYC);
        end
        press(4'h8);
        tests++;
        if (code !== 16'h0008 || digit_count !== 3'd1 || busy !== 1'b0) begin
            fails++; $display("FAIL after_lockout: got code=%h count=%0d busy=%b want 0008/1/0", code, digit_count, busy);
        end
        press(4'hF);
    endtask

    task automatic test_timeout_ignored();
        press(4'h3);
        for (int i = 0; i < T_CYC - 2; i++) tick();
        tests++;
        if (code !== 16'h0003) begin
            fails++; $display("FAIL timeout_early: got code=%h want 0003", code);
        end
        tick();
        tests++;
        if (code !== 16'h0 || digit_count !== 3'd0) begin
            fails++; $display("FAIL timeout: got code=%h count=%0d want 0/0", code, digit_count);
        end
        press(4'h1); press(4'h2); press(4'hA);
        tests++;
        if (code_valid !== 1'b0 || code !== 16'h0012) begin
            fails++; $display("FAIL short_enter: got valid=%b code=%h want 0/0012", code_valid, code);
        end
        press(4'h3); press(4'h4); press(4'h5);
        tests++;
        if (code !== 16'h1234 || digit_count !== 3'd4) begin
            fails++; $display("FAIL fifth_digit: got code=%h count=%0d want 1234/4", code, digit_count);
        end
        press(4'hF);
    endtask

    task automatic test_rst_in_submit();
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hA);
        rst = 1'b1; tick(); rst = 1'b0;
        tests++;
        if (code_valid !== 1'b0 || code !== 16'h0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_submit: got valid=%b code=%h busy=%b want 0/0/0", code_valid, code, busy);
        end
        code_ack = 1'b1; code_ok = 1'b0; tick(); code_ack = 1'b0; tick();
        tests++;
        if (code_valid !== 1'b0 || lockout !== 1'b0 || busy !== 1'b0 || code !== 16'h0) begin
            fails++; $display("FAIL stray_ack: got valid=%b lockout=%b busy=%b code=%h want 0/0/0/0",
                              code_valid, lockout, busy, code);
        end
    endtask

    task automatic test_random();
        int exp_code;
        int r;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                keypress = ~keypress;
                if (keypress) begin
                    r = $urandom_range(0, 13);
                    if (r < 10) key_value = 4'(r);
                    else if (r == 10 || r == 11) key_value = 4'hA;
                    else if (r == 12) key_value = ($urandom_range(0, 1) == 1) ? 4'hE : 4'hF;
                    else key_value = 4'(11 + $urandom_range(0, 2));
                end
            end
            code_ack = ($urandom_range(0, 7) == 0);
            code_ok  = ($urandom_range(0, 2) == 0);
            tick();
            exp_code = model_code();
            tests++;
            if ({code, code_valid, digit_count, lockout, busy} !==
                {exp_code[15:0], mode == 2, 3'(digits.size()), mode == 3, mode >= 2}) begin
                fails++;
                $display("FAIL random_c%0d: got code=%h valid=%b count=%0d lockout=%b busy=%b want %h/%b/%0d/%b/%b",
                         c, code, code_valid, digit_count, lockout, busy,
                         exp_code[15:0], mode == 2, digits.size(), mode == 3, mode >= 2);
            end
            if ({ssd_3, ssd_2, ssd_1, ssd_0} !== exp_code[15:0]) begin
                tests++; fails++;
                $display("FAIL random_ssd_c%0d: got %h want %h", c, {ssd_3, ssd_2, ssd_1, ssd_0}, exp_code[15:0]);
            end
        end
        code_ack = 1'b0; keypress = 1'b0;
    endtask

    initial begin
        test_reset();
        test_submit_ok();
        test_backspace_clear();
        test_held_key();
        test_lockout();
        test_timeout_ignored();
        test_rst_in_submit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
